// File: rtl/pio_tx_pull.sv
// pio_tx_pull: TX FIFO and OSR pull/autopull controller for one PIO state machine
//   clk, reset           : clock, synchronous active-high reset
//   penable              : state-machine clock enable
//   push_*               : system-side FIFO write (valid/ready), fifo_level/empty/full status
//   pull_*, out_req      : decoded PULL/OUT instruction for this cycle, x_reg as PULL noblock source
//   auto_pull, pull_thresh, shift_count : autopull control and OSR fill state
//   osr_set/din/bit_count: OSR load interface, stall: state-machine stall
module pio_tx_pull #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          penable,
    input  logic [31:0]   push_data,
    input  logic          push_valid,
    output logic          push_ready,
    output logic [AW:0]   fifo_level,
    output logic          fifo_empty,
    output logic          fifo_full,
    input  logic          pull_req,
    input  logic          pull_block,
    input  logic          pull_ifempty,
    input  logic          out_req,
    input  logic [31:0]   x_reg,
    input  logic          auto_pull,
    input  logic [4:0]    pull_thresh,
    input  logic [5:0]    shift_count,
    output logic          osr_set,
    output logic [31:0]   osr_din,
    output logic [5:0]    osr_bit_count,
    output logic          stall
);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [5:0]    thr;
    logic          osr_empty, en, noop, pull_fifo, pull_x, pull_stall, auto_pop, auto_stall, push, pop;

    assign fifo_level    = level;
    assign fifo_empty    = level == '0;
    assign fifo_full     = level == (AW+1)'(DEPTH);
    assign push_ready    = !fifo_full;
    assign push          = push_valid && push_ready;
    assign thr           = pull_thresh == '0 ? 6'd32 : {1'b0, pull_thresh};
    assign osr_empty     = shift_count >= thr;
    // Nothing reaches the shifter while reset is held, so a pending PULL dies cleanly.
    assign en            = penable && !reset;
    assign noop          = pull_req && pull_ifempty && !osr_empty;
    assign pull_fifo     = pull_req && !noop && !fifo_empty;
    assign pull_x        = pull_req && !noop && fifo_empty && !pull_block;
    assign pull_stall    = pull_req && !noop && fifo_empty && pull_block;
    assign auto_pop      = !pull_req && auto_pull && osr_empty && !fifo_empty;
    assign auto_stall    = !pull_req && auto_pull && osr_empty && fifo_empty && out_req;
    assign pop           = en && (pull_fifo || auto_pop);
    assign osr_set       = en && (pull_fifo || pull_x || auto_pop);
    assign osr_din       = pop ? mem[rd_ptr] : osr_set ? x_reg : '0;
    assign osr_bit_count = '0;
    assign stall         = en && (pull_stall || auto_stall);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule
